// File: rtl/cpu16_pkg.sv
// cpu16_pkg: definitions shared by the 16-bit single-issue core.
//   - Opcode encodings (instr[15:13]).
//   - Instruction field bit positions.
//   - Fetch-stage state encoding.
//   - A branch-offset helper function.
package cpu16_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_SLTI  = 3'b001;
  localparam logic [2:0] OP_J     = 3'b010;
  localparam logic [2:0] OP_JAL   = 3'b011;
  localparam logic [2:0] OP_LW    = 3'b100;
  localparam logic [2:0] OP_SW    = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_ADDI  = 3'b111;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 13;
  localparam int JTGT_HI = 12;
  localparam int JTGT_LO = 0;
  localparam int IMM7_HI = 6;
  localparam int IMM7_LO = 0;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_t;

  // Word-granular imm7 turned into a signed byte offset.
  function automatic logic signed [15:0] br_offset(input logic [15:0] ir);
    return {{8{ir[IMM7_HI]}}, ir[IMM7_HI:IMM7_LO], 1'b0};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus2  in  16  address of the instruction after the current one
//   instr     in  16  current instruction register
//   jump      in   1  current instruction is a jump
//   branch    in   1  current instruction is a conditional branch
//   zero      in   1  ALU equality flag for the current instruction
//   next_pc   out 16  address of the next instruction to fetch
// Priority: jump, then taken branch, then sequential. Adds wrap mod 2^16.
module next_pc_logic
  import cpu16_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] pc_plus2,
  input  logic [DATA_W-1:0] instr,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  output logic [DATA_W-1:0] next_pc
);

  logic signed [DATA_W-1:0] offset;
  logic [DATA_W-1:0]        br_target;
  logic [DATA_W-1:0]        jmp_target;
  logic                     unused_opc;

  // The opcode field is decoded by the control unit, not here.
  assign unused_opc = ^instr[OPC_HI:OPC_LO];

  assign offset     = br_offset(instr);
  assign br_target  = pc_plus2 + $unsigned(offset);
  // Jumps stay within the current 16 KiB region selected by pc_plus2[15:14].
  assign jmp_target = {pc_plus2[15:14], instr[JTGT_HI:JTGT_LO], 1'b0};

  always_comb begin
    next_pc = pc_plus2;
    if (jump) begin
      next_pc = jmp_target;
    end else if (branch && zero) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit single-issue core.
// Ports:
//   clk, rst            core clock; asynchronous reset, active low
//   imem_req/addr       fetch request (held until ack) and byte address (= pc)
//   imem_ack/rdata      one-cycle ack pulse with the returned instruction word
//   instr, opcode       instruction register and its opcode field
//   instr_valid/ready   handshake to decode; instr_fire = valid & ready
//   jump, branch, zero  control-flow outcome for the current instruction
//   pc, pc_plus2        current instruction address and its link value
// The stage alternates FETCH (request outstanding) and ISSUE (instruction
// waiting for decode), so one instruction is in flight at a time.
module fetch_unit
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [2:0]        opcode,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              instr_fire,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus2
);

  fetch_state_t      state, state_n;
  logic              req_q;
  logic              ack_take;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] next_pc;

  // req is registered from the next state so it is low throughout reset and
  // rises one cycle after release, yet still drops on the ack edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      req_q <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= (state_n == FETCH);
    end
  end

  always_comb begin
    state_n  = state;
    ack_take = 1'b0;
    case (state)
      FETCH: begin
        // An ack with no request outstanding (first cycle after reset) is stray.
        if (req_q && imem_ack) begin
          ack_take = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (ack_take) begin
        instr_q <= imem_rdata;
      end
      if (instr_fire) begin
        pc_q <= next_pc;
      end
    end
  end

  next_pc_logic #(
    .DATA_W(DATA_W)
  ) u_next_pc (
    .pc_plus2(pc_plus2),
    .instr   (instr_q),
    .jump    (jump),
    .branch  (branch),
    .zero    (zero),
    .next_pc (next_pc)
  );

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPC_HI:OPC_LO];
  assign instr_valid = (state == ISSUE);
  assign instr_fire  = instr_valid & instr_ready;
  assign pc          = pc_q;
  assign pc_plus2    = pc_q + 16'd2;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A small memory model acks
// requests with chosen words; each ack pushes the expected instruction/pc,
// which is popped and compared when instr_valid appears. The next-pc model
// uses plain integer arithmetic.
module tb_fetch_unit;
  import cpu16_pkg::*;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        instr_fire;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [15:0] pc;
  logic [15:0] pc_plus2;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb_q[$];
  logic [15:0] mpc;
  logic [15:0] cur_instr;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(16'h0000),
    .DATA_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_fire (instr_fire),
    .jump       (jump),
    .branch     (branch),
    .zero       (zero),
    .pc         (pc),
    .pc_plus2   (pc_plus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] p, input logic [15:0] ir,
                                             input logic j, input logic b, input logic z);
    int pp;
    int off;
    pp = (int'(p) + 2) % 65536;
    if (j) return 16'((pp & 32'hC000) | (int'(ir[12:0]) * 2));
    if (b && z) begin
      off = int'(ir[6:0]);
      if (off >= 64) off = off - 128;
      return 16'((pp + 2 * off + 65536) % 65536);
    end
    return 16'(pp);
  endfunction

  // Waits (bounded) for a request, holds it waitn cycles, then acks with word.
  task automatic do_fetch(input logic [15:0] word, input int waitn);
    int   n;
    exp_t e;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", imem_req, 1);
    check("imem_addr", imem_addr, mpc);
    for (int i = 0; i < waitn; i++) begin
      @(negedge clk);
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, mpc);
      check("valid_wait", instr_valid, 0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    e.instr    = word;
    e.pc       = mpc;
    sb_q.push_back(e);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'hDEAD;
    check("req_drop", imem_req, 0);
    check("valid_lat", instr_valid, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cur_instr = e.instr;
      check("instr", instr, e.instr);
      check("opcode", opcode, e.instr[15:13]);
      check("pc", pc, e.pc);
      check("pc_plus2", pc_plus2, 16'(e.pc + 16'd2));
    end else begin
      check("sb_nonempty", 0, 1);
    end
  endtask

  // Stalls for stall cycles (with a stray ack in the first), then fires.
  task automatic do_issue(input logic j, input logic b, input logic z, input int stall);
    logic [15:0] nx;
    if (stall > 0) begin
      imem_ack   = 1'b1;
      imem_rdata = 16'hBEEF;
    end
    for (int i = 0; i < stall; i++) begin
      instr_ready = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;
      check("stall_valid", instr_valid, 1);
      check("stall_req", imem_req, 0);
      check("stall_instr", instr, cur_instr);
      check("stall_pc", pc, mpc);
      check("stall_fire", instr_fire, 0);
    end
    instr_ready = 1'b1;
    jump        = j;
    branch      = b;
    zero        = z;
    #1;
    check("fire", instr_fire, 1);
    nx = model_next(mpc, cur_instr, j, b, z);
    @(negedge clk);
    instr_ready = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    check("fire_pulse", instr_fire, 0);
    check("valid_drop", instr_valid, 0);
    check("req_after_fire", imem_req, 1);
    mpc = nx;
    check("next_addr", imem_addr, mpc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0000;
    instr_ready = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    mpc         = 16'h0000;
    cur_instr   = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 16'h0000);
    check("rst_opcode", opcode, 3'b000);
    check("rst_pc", pc, 16'h0000);
    rst = 1'b1;
    #1;
    check("req_before_edge", imem_req, 0);
    @(negedge clk);
    check("req_rise", imem_req, 1);

    // First fetch: ack two cycles after the request.
    do_fetch(16'h0123, 2);
    check("first_instr", instr, 16'h0123);
    check("first_pp2", pc_plus2, 16'h0002);
    do_issue(1'b0, 1'b0, 1'b0, 3);
    check("seq_addr", imem_addr, 16'h0002);

    // Jump to 0x0010, then the jump test from there.
    do_fetch(16'h4008, 0);
    do_issue(1'b1, 1'b0, 1'b0, 0);
    check("to_0010", imem_addr, 16'h0010);
    do_fetch(16'h4005, 1);
    do_issue(1'b1, 1'b0, 1'b0, 0);
    check("jump_addr", imem_addr, 16'h000A);

    // BEQ taken from 0x0020.
    do_fetch(16'h4010, 0);
    do_issue(1'b1, 1'b0, 1'b0, 0);
    do_fetch(16'hC07E, 1);
    do_issue(1'b0, 1'b1, 1'b1, 0);
    check("beq_taken", imem_addr, 16'h001E);

    // BEQ not taken from 0x0020.
    do_fetch(16'h4010, 0);
    do_issue(1'b1, 1'b0, 1'b0, 0);
    do_fetch(16'hC07E, 0);
    do_issue(1'b0, 1'b1, 1'b0, 0);
    check("beq_nottaken", imem_addr, 16'h0022);

    // Jump and branch together: jump wins.
    do_fetch(16'h4010, 0);
    do_issue(1'b1, 1'b0, 1'b0, 0);
    do_fetch(16'hC07E, 0);
    do_issue(1'b1, 1'b1, 1'b1, 0);
    check("jump_priority", imem_addr, 16'h00FC);

    // Reach 0xFFFE via a backward branch from 0, then wrap.
    do_fetch(16'h4000, 0);
    do_issue(1'b1, 1'b0, 1'b0, 0);
    do_fetch(16'hC07E, 0);
    do_issue(1'b0, 1'b1, 1'b1, 2);
    check("to_fffe", imem_addr, 16'hFFFE);
    do_fetch(16'h2345, 1);
    check("wrap_pp2", pc_plus2, 16'h0000);
    do_issue(1'b0, 1'b0, 1'b0, 0);
    check("wrap_addr", imem_addr, 16'h0000);

    // Jump away so the mid-fetch reset is observable as a return to RESET_PC.
    do_fetch(16'h4040, 0);
    do_issue(1'b1, 1'b0, 1'b0, 0);
    check("to_0080", imem_addr, 16'h0080);
    @(negedge clk);
    check("pre_rst_req", imem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_req_drop", imem_req, 0);
    check("async_valid", instr_valid, 0);
    check("async_pc", pc, 16'h0000);
    imem_ack   = 1'b1;
    imem_rdata = 16'hFFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("stray_ack_instr", instr, 16'h0000);
    check("stray_ack_valid", instr_valid, 0);
    rst = 1'b1;
    mpc = 16'h0000;
    @(negedge clk);
    check("post_rst_req", imem_req, 1);
    check("post_rst_addr", imem_addr, 16'h0000);
    check("post_rst_valid", instr_valid, 0);
    do_fetch(16'hE001, 1);
    do_issue(1'b0, 1'b0, 1'b0, 0);
    check("post_rst_next", imem_addr, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder/control unit in the 16-bit single-issue core.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Latches each returned word into an instruction register and presents opcode/fields to decode, with a valid/ready handshake.
- Computes the next PC from the jump/branch/zero outcome that the datapath returns for the issued instruction.

Parameters:
RESET_PC  16'h0000  PC loaded on reset; must be even.
DATA_W  16  instruction and address width; only 16 is supported.

Ports:
clk  in  1  core clock, rising-edge.
rst  in  1  asynchronous reset, active-low (asserted when 0).
imem_req  out  1  fetch request, held until ack.
imem_addr  out  16  byte address of the requested instruction; equals pc.
imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
imem_rdata  in  16  returned instruction word.
instr  out  16  instruction register.
opcode  out  3  instr[15:13], to control unit.
instr_valid  out  1  instr holds an unissued instruction.
instr_ready  in  1  downstream accepts instr (stall when 0).
instr_fire  out  1  instr_valid & instr_ready; retire strobe.
jump  in  1  from control unit, for the current instr.
branch  in  1  from control unit, for the current instr.
zero  in  1  ALU equality flag, for the current instr.
pc  out  16  address of the current instruction.
pc_plus2  out  16  pc+2; JAL link value.

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, pc=RESET_PC, instr=16'h0000.
  - instr_valid=0, imem_req=0 (registered; drops immediately).
  - Any in-flight memory transaction is abandoned; imem must also drop it on reset.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack: instr<=imem_rdata, state<=ISSUE.
    - imem_req deasserts on the same edge.
  - ISSUE: instr_valid=1, imem_req=0.
    - On instr_fire: pc<=next_pc, state<=FETCH, instr_valid<=0.
    - With instr_ready=0: instr, pc and outputs held stable indefinitely.
- Latency:
  - imem_req rises the first cycle after reset release (registered from state).
  - instr_valid rises the cycle after imem_ack.
  - The next imem_req rises the cycle after instr_fire.
  - Minimum 2 cycles per instruction with a zero-wait ack (req and ack in the same cycle).
- imem_ack outside FETCH is ignored; instr is not overwritten.
- imem_addr and imem_req are stable while waiting for ack.
- next_pc is combinational, evaluated only at instr_fire. Priority:
  - jump=1: {pc_plus2[15:14], instr[12:0], 1'b0}.
  - else branch=1 and zero=1: pc_plus2 + {{8{instr[6]}}, instr[6:0], 1'b0}.
  - else: pc_plus2.
- Arithmetic:
  - All adds are modulo 2^16; pc 16'hFFFE + 2 wraps to 16'h0000 with no flag.
  - Bit 0 of pc is always 0.
- opcode = instr[15:13] at all times.
  - The reset value 000 decodes as R-type; downstream must gate writes with instr_fire.
- jump/branch/zero are sampled only in the instr_fire cycle; their values are don't-care in other cycles.

Decomposition:
- Shared package cpu16_pkg holds:
  - opcode constants: OP_RTYPE=000, OP_SLTI=001, OP_J=010, OP_JAL=011, OP_LW=100, OP_SW=101, OP_BEQ=110, OP_ADDI=111;
  - instruction field bit positions (opcode 15:13, jump target 12:0, imm7 6:0);
  - the fetch state enum (FETCH, ISSUE).
- One combinational sub-module, next_pc_logic: inputs pc_plus2, instr, jump, branch, zero; output next_pc. Unit-testable on its own.

Test Plan:
- Reset release, ack 2 cycles after req with rdata 16'h0123:
  - imem_addr=0x0000 while waiting;
  - instr_valid=1 the cycle after ack;
  - instr=0x0123, opcode=000, pc_plus2=0x0002.
- Stall: hold instr_ready=0 for 3 cycles in ISSUE -> instr, pc and instr_valid constant, imem_req=0 throughout; on ready=1, instr_fire pulses for exactly one cycle.
- Jump: pc=0x0010, instr=16'h4005, jump=1 -> next imem_addr=0x000A.
- BEQ: pc=0x0020, instr[6:0]=7'h7E, branch=1:
  - zero=1 -> next imem_addr=0x001E;
  - repeat with zero=0 -> 0x0022;
  - jump=1 and branch=1 together -> jump target wins.
- Wrap: pc=0xFFFE, non-control instruction fired -> next imem_addr=0x0000.
- Mid-fetch reset: assert rst=0 while imem_req=1 and before ack:
  - imem_req=0 immediately, without waiting for a clock edge;
  - a stray ack during reset is ignored;
  - after release, the first request is to RESET_PC and instr_valid=0 until the new ack.
